half_adder_reg: RTL and testbench

- Registered bank of WIDTH independent 1-bit half adders. Each lane i computes sum = a^b and carry = a&b.
- Results are captured into output registers one clock after a valid input beat.
- Leaf arithmetic primitive used by larger adder/counter datapaths. Lane 0 with WIDTH=1 is the classic single half adder.

---
 rtl/half_adder_pkg.sv | 17 +
 rtl/half_adder_cell.sv | 17 +
 rtl/half_adder_reg.sv | 103 ++++++++++
 tb/tb_half_adder_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder bank: width limits and the
// reference {carry,sum} function used by the datapath and its checkers.
package half_adder_pkg;

    localparam int HA_DEFAULT_WIDTH = 1;
    localparam int HA_MAX_WIDTH     = 64;

    typedef struct packed {
        logic carry;
        logic sum;
    } ha_res_t;

    function automatic logic [1:0] ha_ref(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane: sum = a^b, carry = a&b.
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic bit1_i,
    input  logic bit2_i,
    output logic sum_o,
    output logic carry_o
);

    ha_res_t res_s;

    assign res_s   = ha_res_t'(ha_ref(bit1_i, bit2_i));
    assign sum_o   = res_s.sum;
    assign carry_o = res_s.carry;

endmodule

// File: rtl/half_adder_reg.sv
// Registered bank of WIDTH independent half adders with one-cycle latency.
// Optional registered parity output enabled by macro HALF_ADDER_PARITY_EN.
module half_adder_reg
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] bit1_i,
    input  logic [WIDTH-1:0] bit2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o,
    output logic             carry_any_o
`ifdef HALF_ADDER_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] carry_s;

    logic             valid_d,     valid_q;
    logic [WIDTH-1:0] sum_d,       sum_q;
    logic [WIDTH-1:0] carry_d,     carry_q;
    logic             carry_any_d, carry_any_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .bit1_i  (bit1_i[i]),
            .bit2_i  (bit2_i[i]),
            .sum_o   (sum_s[i]),
            .carry_o (carry_s[i])
        );
    end

    // Next state: capture lane results on a valid beat, otherwise hold so
    // undefined operands never reach the output registers.
    always_comb begin
        valid_d     = valid_i;
        sum_d       = sum_q;
        carry_d     = carry_q;
        carry_any_d = carry_any_q;
        if (valid_i) begin
            sum_d       = sum_s;
            carry_d     = carry_s;
            carry_any_d = |carry_s;
        end else begin
            sum_d       = sum_q;
            carry_d     = carry_q;
            carry_any_d = carry_any_q;
        end
    end

    // Output registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q     <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            carry_any_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            carry_any_q <= carry_any_d;
        end
    end

    assign valid_o     = valid_q;
    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign carry_any_o = carry_any_q;

`ifdef HALF_ADDER_PARITY_EN
    logic parity_d, parity_q;

    // Parity of the next sum/carry vectors, held with them when idle.
    always_comb begin
        parity_d = parity_q;
        if (valid_i) begin
            parity_d = ^(sum_s ^ carry_s);
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity register, cleared with the rest of the outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// Self-checking bench for half_adder_reg (WIDTH=8): directed cases on the
// low lanes plus randomized beats against a lane-arithmetic reference model.
module tb_half_adder_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic [W-1:0] bit1;
    logic [W-1:0] bit2;
    logic         valid_out;
    logic [W-1:0] sum_out;
    logic [W-1:0] carry_out;
    logic         carry_any_out;
`ifdef HALF_ADDER_PARITY_EN
    logic         parity_out;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic         exp_valid;
    logic [W-1:0] exp_sum;
    logic [W-1:0] exp_carry;
    logic         exp_any;
    logic         exp_par;

    half_adder_reg #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_i     (valid_in),
        .bit1_i      (bit1),
        .bit2_i      (bit2),
        .valid_o     (valid_out),
        .sum_o       (sum_out),
        .carry_o     (carry_out),
        .carry_any_o (carry_any_out)
`ifdef HALF_ADDER_PARITY_EN
        ,
        .parity_o    (parity_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each lane adds its two bits as integers; bit0 is sum, bit1 carry.
    task automatic model_beat(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        int nz;
        exp_valid = v;
        if (v) begin
            nz = 0;
            for (int i = 0; i < W; i++) begin
                t = int'(a[i]) + int'(b[i]);
                exp_sum[i]   = (t == 1);
                exp_carry[i] = (t == 2);
                if (t != 0) nz++;
            end
            exp_any = (exp_carry != '0);
            exp_par = (nz % 2) == 1;
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_sum   = '0;
        exp_carry = '0;
        exp_any   = 1'b0;
        exp_par   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
        chk({tag, ".sum"},   64'(sum_out),   64'(exp_sum));
        chk({tag, ".carry"}, 64'(carry_out), 64'(exp_carry));
        chk({tag, ".any"},   64'(carry_any_out), 64'(exp_any));
`ifdef HALF_ADDER_PARITY_EN
        chk({tag, ".parity"}, 64'(parity_out), 64'(exp_par));
`endif
    endtask

    // Drive one beat at a falling edge, let one rising edge pass, then check.
    task automatic step(input string tag, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_in = v;
        bit1     = a;
        bit2     = b;
        model_beat(v, a, b);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        bit1     = '0;
        bit2     = '0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-lane truth table, back-to-back
        step("tt00", 1'b1, 8'h00, 8'h00);
        step("tt01", 1'b1, 8'h00, 8'h01);
        step("tt10", 1'b1, 8'h01, 8'h00);
        step("tt11", 1'b1, 8'h01, 8'h01);

        // Hold while idle with changing operands
        for (int k = 0; k < 3; k++) step("hold", 1'b0, 8'h00, 8'h01);

        // Four-lane cases
        step("w4a", 1'b1, 8'h0C, 8'h0A);
        chk("w4a.sum_const", 64'(sum_out), 64'h06);
        chk("w4a.carry_const", 64'(carry_out), 64'h08);
        step("w4b", 1'b1, 8'h05, 8'h0A);
        chk("w4b.sum_const", 64'(sum_out), 64'h0F);

        // Async reset mid-cycle with a pending beat
        step("prerst", 1'b1, 8'h03, 8'h01);
        valid_in = 1'b1;
        bit1     = 8'hFF;
        bit2     = 8'hFF;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("rst_held");
        rst_n = 1'b1;
        step("post_rst", 1'b1, 8'h01, 8'h00);

        // Randomized beats, occasionally unknown operands while idle
        for (int k = 0; k < 10000; k++) begin
            logic         v;
            logic [W-1:0] a;
            logic [W-1:0] b;
            v = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            if (!v && ($urandom_range(0, 3) == 0)) a = 'x;
            step("rand", v, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
